mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// Shares the single 8-bit memory port between the CPU core (requester 0) and the IO/DMA
// engine (requester 1). Arbitrates once per transaction with fixed CPU priority plus a
// starvation bound for IO, then sequences one access: grant, MEM_LATENCY access cycles,
// and a one-cycle response. Sits between the core/IO blocks and the RAM.
// PARAMETERS
// ADDR_WIDTH   8  memory address width
// DATA_WIDTH   8  memory data width
// MEM_LATENCY  1  cycles mem_en is held per access (>=1); read data sampled on the last one
// MAX_WAIT     4  IO wait-cycle count at which IO beats the CPU in arbitration (>=1)
// PORTS
// clk        in   1           system clock, all state changes on posedge
// reset      in   1           synchronous, active-high
// cpu_req    in   1           CPU access request (level)
// cpu_we     in   1           1 = write, 0 = read
// cpu_addr   in   ADDR_WIDTH  CPU address
// cpu_wdata  in   DATA_WIDTH  CPU write data
// cpu_gnt    out  1           CPU owns the bus (ACCESS and RESP states)
// cpu_done   out  1           one-cycle pulse: CPU access complete
// cpu_rdata  out  DATA_WIDTH  CPU read data, valid from cpu_done, held until next CPU read
// io_req, io_we, io_addr, io_wdata, io_gnt, io_done, io_rdata   same as cpu_* for IO
// mem_en     out  1           memory enable
// mem_we     out  1           memory write enable
// mem_addr   out  ADDR_WIDTH  memory address
// mem_wdata  out  DATA_WIDTH  memory write data
// mem_rdata  in   DATA_WIDTH  memory read data
// busy       out  1           state != IDLE
// BEHAVIOUR
// - Reset: state IDLE, io_wait 0, every output 0 (incl. both rdata) on the next edge.
// - States: IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP (1 cycle) -> IDLE.
// - IDLE: req sampled only here. Both low: stay. One high: grant it. Both high: IO wins
//   if io_wait >= MAX_WAIT, else CPU. On grant, owner, we, addr, wdata latched; go ACCESS.
// - ACCESS: mem_en=1, mem_we/addr/wdata from latched values; gnt of owner = 1. Cycle
//   counter counts 0..MEM_LATENCY-1; on the last cycle latch mem_rdata (reads only) into
//   owner's rdata and go RESP.
// - RESP: owner's done=1 and gnt=1, mem_en=0. Next state IDLE unconditionally.
// - Outside ACCESS: mem_en, mem_we, mem_addr, mem_wdata all 0.
// - Timing: req high in IDLE cycle n -> gnt from n+1, done at n+1+MEM_LATENCY, IDLE at
//   n+2+MEM_LATENCY. Non-owner's rdata never changes; writes leave owner's rdata unchanged.
// - Requester drops req at the edge ending its done cycle; req still high in the next
//   IDLE cycle is a new transaction (back-to-back allowed, one IDLE bubble between).
// - Inputs changed or req dropped during ACCESS/RESP: ignored; access completes, done pulses.
// - io_wait: +1 each cycle io_req=1 and IO not owner (saturating at MAX_WAIT, width
//   $clog2(MAX_WAIT+1)); cleared to 0 on the edge that grants IO; unchanged otherwise.
// - Reset mid-transaction: abort; next cycle IDLE, mem_en=0, no done pulse, rdata cleared.
// TESTING (MEM_LATENCY=1, MAX_WAIT=4 unless noted)
// 1. CPU read 0x10, mem_rdata=0xA5 -> cycle1 cpu_gnt=1, mem_en=1, mem_addr=0x10, mem_we=0;
//    cycle2 cpu_done=1, cpu_rdata=0xA5; cycle3 busy=0; io_* stay 0.
// 2. IO write 0x3F<-0x5A alone -> one cycle mem_en=1, mem_we=1, mem_addr=0x3F,
//    mem_wdata=0x5A; io_done next cycle; io_rdata stays 0.
// 3. cpu_req and io_req rise together, one access each -> CPU served first, IO granted
//    in the IDLE cycle after CPU's RESP; exactly one done pulse each.
// 4. cpu_req and io_req held high continuously -> grant order CPU, CPU, IO, CPU, CPU, IO;
//    io_wait peaks at 4 and returns to 0 on each IO grant.
// 5. reset asserted in ACCESS cycle -> next cycle busy=0, mem_en=0, no cpu_done/io_done.
// 6. MEM_LATENCY=3, CPU read 0x22 -> mem_en high cycles 1-3, rdata sampled cycle 3,
//    cpu_done cycle 4; changing cpu_addr in cycle 2 leaves mem_addr=0x22.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory port between the CPU (requester 0) and the IO/DMA engine
//   (requester 1). Arbitration happens only in IDLE: the CPU has fixed priority
//   unless IO has waited MAX_WAIT cycles. Each transaction is a grant, then
//   MEM_LATENCY access cycles with mem_en high, then a one-cycle done pulse.
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_cpu_* / i_io_*               requester inputs: req (level), we, addr, wdata
//   o_cpu_* / o_io_*               gnt (ACCESS+RESP), done (RESP pulse), rdata (held)
//   o_mem_en/we/addr/wdata         memory port, all zero outside ACCESS
//   i_mem_rdata                    memory read data, sampled on last access cycle
//   o_busy                         arbiter is not idle
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_done,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  input  logic                  i_io_req,
  input  logic                  i_io_we,
  input  logic [ADDR_WIDTH-1:0] i_io_addr,
  input  logic [DATA_WIDTH-1:0] i_io_wdata,
  output logic                  o_io_gnt,
  output logic                  o_io_done,
  output logic [DATA_WIDTH-1:0] o_io_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  // Transaction latched at grant; io=1 means IO owns the bus.
  typedef struct packed {
    logic                  io;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } txn_t;

  state_t                r_state, w_next;
  txn_t                  r_txn, w_txn_new;
  logic [CW-1:0]         r_cnt;
  logic [WW-1:0]         r_io_wait;
  logic [DATA_WIDTH-1:0] r_cpu_rdata, r_io_rdata;
  logic                  w_grant_io, w_last, w_io_owner;

  always_comb begin
    w_grant_io = i_io_req && (!i_cpu_req || (r_io_wait >= WW'(MAX_WAIT)));
    w_last     = (r_cnt == CW'(MEM_LATENCY - 1));
    w_io_owner = (r_state != S_IDLE) && r_txn.io;
    w_txn_new  = w_grant_io ? '{1'b1, i_io_we, i_io_addr, i_io_wdata}
                            : '{1'b0, i_cpu_we, i_cpu_addr, i_cpu_wdata};

    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_cpu_req || i_io_req) w_next = S_ACCESS;
      S_ACCESS: if (w_last) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    o_busy      = (r_state != S_IDLE);
    o_cpu_gnt   = o_busy && !r_txn.io;
    o_io_gnt    = o_busy && r_txn.io;
    o_cpu_done  = (r_state == S_RESP) && !r_txn.io;
    o_io_done   = (r_state == S_RESP) && r_txn.io;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (r_state == S_ACCESS) begin
      o_mem_en    = 1'b1;
      o_mem_we    = r_txn.we;
      o_mem_addr  = r_txn.addr;
      o_mem_wdata = r_txn.wdata;
    end
    o_cpu_rdata = r_cpu_rdata;
    o_io_rdata  = r_io_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_txn       <= '0;
      r_cnt       <= '0;
      r_io_wait   <= '0;
      r_cpu_rdata <= '0;
      r_io_rdata  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (i_cpu_req || i_io_req) begin
          r_txn <= w_txn_new;
          r_cnt <= '0;
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last && !r_txn.we) begin
            if (r_txn.io) r_io_rdata  <= i_mem_rdata;
            else          r_cpu_rdata <= i_mem_rdata;
          end
        end
        default: ;
      endcase

      // Starvation counter: cleared when IO wins, otherwise counts every
      // cycle IO is asking but does not own the bus.
      if (r_state == S_IDLE && w_grant_io)
        r_io_wait <= '0;
      else if (i_io_req && !w_io_owner && (r_io_wait < WW'(MAX_WAIT)))
        r_io_wait <= r_io_wait + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives two arbiters (MEM_LATENCY 1 and 3) with identical stimulus and checks
// every cycle against a transaction-level model, plus literal spot checks.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cpu_req, cpu_we, io_req, io_we;
  logic [7:0] cpu_addr, cpu_wdata, io_addr, io_wdata, mem_rdata;
  logic [1:0] cpu_gnt, cpu_done, io_gnt, io_done, mem_en, mem_we, busy;
  logic [1:0][7:0] cpu_rdata, io_rdata, mem_addr, mem_wdata;

  mem_bus_arbiter #(.MEM_LATENCY(1), .MAX_WAIT(4)) u0 (
    .i_clk(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt[0]), .o_cpu_done(cpu_done[0]), .o_cpu_rdata(cpu_rdata[0]),
    .i_io_req(io_req), .i_io_we(io_we), .i_io_addr(io_addr), .i_io_wdata(io_wdata),
    .o_io_gnt(io_gnt[0]), .o_io_done(io_done[0]), .o_io_rdata(io_rdata[0]),
    .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata), .o_busy(busy[0]));

  mem_bus_arbiter #(.MEM_LATENCY(3), .MAX_WAIT(4)) u1 (
    .i_clk(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt[1]), .o_cpu_done(cpu_done[1]), .o_cpu_rdata(cpu_rdata[1]),
    .i_io_req(io_req), .i_io_we(io_we), .i_io_addr(io_addr), .i_io_wdata(io_wdata),
    .o_io_gnt(io_gnt[1]), .o_io_done(io_done[1]), .o_io_rdata(io_rdata[1]),
    .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata), .o_busy(busy[1]));

  // Model: a transaction is (owner, fields, start time); t counts cycles since grant.
  int         LAT[2] = '{1, 3};
  bit         m_busy[2], m_io[2], m_we[2];
  int         m_t[2], m_wait[2];
  logic [7:0] m_addr[2], m_wdata[2], m_crd[2], m_ird[2];
  int         n_chk = 0, n_pass = 0;

  task automatic chk(string nm, logic [38:0] a, logic [38:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  function automatic logic [38:0] exp_vec(int k);
    logic acc, resp;
    acc  = m_busy[k] && (m_t[k] <= LAT[k]);
    resp = m_busy[k] && (m_t[k] == LAT[k] + 1);
    return {m_busy[k], m_busy[k] && !m_io[k], resp && !m_io[k], m_busy[k] && m_io[k],
            resp && m_io[k], acc, acc && m_we[k], acc ? m_addr[k] : 8'h00,
            acc ? m_wdata[k] : 8'h00, m_crd[k], m_ird[k]};
  endfunction

  function automatic logic [38:0] act_vec(int k);
    return {busy[k], cpu_gnt[k], cpu_done[k], io_gnt[k], io_done[k], mem_en[k], mem_we[k],
            mem_addr[k], mem_wdata[k], cpu_rdata[k], io_rdata[k]};
  endfunction

  task automatic model_edge(int k);
    if (rst) begin
      m_busy[k] = 0; m_io[k] = 0; m_we[k] = 0; m_t[k] = 0; m_wait[k] = 0;
      m_addr[k] = 0; m_wdata[k] = 0; m_crd[k] = 0; m_ird[k] = 0;
    end else if (!m_busy[k]) begin
      if (io_req && (!cpu_req || m_wait[k] >= 4)) begin
        m_busy[k] = 1; m_t[k] = 1; m_io[k] = 1; m_we[k] = io_we;
        m_addr[k] = io_addr; m_wdata[k] = io_wdata; m_wait[k] = 0;
      end else if (cpu_req) begin
        m_busy[k] = 1; m_t[k] = 1; m_io[k] = 0; m_we[k] = cpu_we;
        m_addr[k] = cpu_addr; m_wdata[k] = cpu_wdata;
        if (io_req && m_wait[k] < 4) m_wait[k]++;
      end
    end else begin
      if (io_req && !m_io[k] && m_wait[k] < 4) m_wait[k]++;
      if (m_t[k] == LAT[k] && !m_we[k]) begin
        if (m_io[k]) m_ird[k] = mem_rdata; else m_crd[k] = mem_rdata;
      end
      if (m_t[k] == LAT[k] + 1) m_busy[k] = 0; else m_t[k]++;
    end
  endtask

  // One clock: model follows the edge, then all outputs checked mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge(0); model_edge(1);
    @(negedge clk);
    chk("model_u0", act_vec(0), exp_vec(0));
    chk("model_u1", act_vec(1), exp_vec(1));
  endtask

  task automatic idle(int n);
    cpu_req = 0; io_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  int g[6];
  int ng;
  logic pb;

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; io_req = 0; io_we = 0;
    cpu_addr = 0; cpu_wdata = 0; io_addr = 0; io_wdata = 0; mem_rdata = 0;
    step(); step();
    chk("reset_outputs_u0", act_vec(0), 39'd0);
    chk("reset_outputs_u1", act_vec(1), 39'd0);
    rst = 0;
    step();

    // CPU read 0x10 -> 0xA5
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; step();
    chk("t1_cpu_gnt", cpu_gnt[0], 1); chk("t1_mem_en", mem_en[0], 1);
    chk("t1_mem_addr", mem_addr[0], 8'h10); chk("t1_mem_we", mem_we[0], 0);
    chk("t1_io_gnt", io_gnt[0], 0);
    mem_rdata = 8'hA5; step();
    chk("t1_cpu_done", cpu_done[0], 1); chk("t1_cpu_rdata", cpu_rdata[0], 8'hA5);
    cpu_req = 0; step();
    chk("t1_busy", busy[0], 0); chk("t1_io_rdata", io_rdata[0], 0);
    idle(6);

    // IO write 0x3F <- 0x5A
    io_req = 1; io_we = 1; io_addr = 8'h3F; io_wdata = 8'h5A; step();
    chk("t2_mem_en", mem_en[0], 1); chk("t2_mem_we", mem_we[0], 1);
    chk("t2_mem_addr", mem_addr[0], 8'h3F); chk("t2_mem_wdata", mem_wdata[0], 8'h5A);
    io_req = 0; step();
    chk("t2_io_done", io_done[0], 1); chk("t2_mem_en_off", mem_en[0], 0);
    chk("t2_io_rdata", io_rdata[0], 0);
    idle(6);

    // Simultaneous requests: CPU first, IO in the IDLE cycle after CPU's RESP
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01; io_req = 1; io_we = 0; io_addr = 8'h02;
    step(); chk("t3_c1_cpu_gnt", cpu_gnt[0], 1); chk("t3_c1_io_gnt", io_gnt[0], 0);
    step(); chk("t3_c2_cpu_done", cpu_done[0], 1);
    cpu_req = 0;
    step(); chk("t3_c3_idle", busy[0], 0);
    step(); chk("t3_c4_io_gnt", io_gnt[0], 1);
    step(); chk("t3_c5_io_done", io_done[0], 1); chk("t3_c5_cpu_done", cpu_done[0], 0);
    io_req = 0;
    idle(6);

    // Both held high: grant order CPU, CPU, IO, CPU, CPU, IO
    rst = 1; step(); rst = 0;
    cpu_req = 1; io_req = 1; ng = 0; pb = busy[0];
    for (int i = 0; i < 6; i++) g[i] = -1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (busy[0] && !pb && ng < 6) begin g[ng] = io_gnt[0] ? 1 : 0; ng++; end
      pb = busy[0];
    end
    chk("t4_grant0", g[0], 0); chk("t4_grant1", g[1], 0); chk("t4_grant2", g[2], 1);
    chk("t4_grant3", g[3], 0); chk("t4_grant4", g[4], 0); chk("t4_grant5", g[5], 1);
    idle(6);

    // Reset in ACCESS aborts with no done pulse
    cpu_req = 1; cpu_addr = 8'h44; step();
    rst = 1; cpu_req = 0; step();
    chk("t5_busy", busy, 2'b00); chk("t5_mem_en", mem_en, 2'b00);
    chk("t5_done", {cpu_done, io_done}, 4'b0000);
    rst = 0; idle(2);

    // Latency 3 read 0x22 on u1, address changed mid-access
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h22; step();
    chk("t6_c1_mem_en", mem_en[1], 1); chk("t6_c1_mem_addr", mem_addr[1], 8'h22);
    cpu_addr = 8'h77; mem_rdata = 8'h11; step();
    chk("t6_c2_mem_addr", mem_addr[1], 8'h22); chk("t6_c2_done", cpu_done[1], 0);
    mem_rdata = 8'h3C; step();
    chk("t6_c3_mem_en", mem_en[1], 1);
    step();
    chk("t6_c4_cpu_done", cpu_done[1], 1); chk("t6_c4_rdata", cpu_rdata[1], 8'h3C);
    chk("t6_c4_mem_en", mem_en[1], 0);
    idle(6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      io_req    = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1);
      io_we     = $urandom_range(0, 1);
      cpu_addr  = 8'($urandom); cpu_wdata = 8'($urandom);
      io_addr   = 8'($urandom); io_wdata  = 8'($urandom);
      mem_rdata = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
